crypt_stream_ctrl: RTL
======================

# crypt_stream_ctrl

Upstream sequencer for the FastModExp engine. Accepts a plaintext/ciphertext byte stream, packs bytes into blocks numerically below the loaded modulus, issues one exponentiation per block, and presents each 32-bit result on a ready/valid output. It holds the key (exponent, modulus) and drives FastModExp's `base`/`exponent`/`modulo`/`start` inputs while consuming its `result`/`done`.

## Interface
- `BPB`, 3: bytes per block (1..3); block value range 0 .. 2^(8·BPB)-1
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `key_load`  in  1  one-cycle strobe, latch `key_exp`/`key_mod`
- `key_exp`  in  32  public or private exponent
- `key_mod`  in  32  modulus
- `key_err`  out  1  high when registered modulus ≤ 2^(8·BPB)-1
- `in_data`  in  8  input byte
- `in_valid`  in  1  byte present
- `in_last`  in  1  byte closes the stream; forces short block
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `exp_base`  out  32  to FastModExp `base`
- `exp_exponent`  out  32  to FastModExp `exponent` (key register)
- `exp_modulo`  out  32  to FastModExp `modulo` (key register)
- `exp_start`  out  1  one-cycle start pulse to FastModExp
- `exp_result`  in  32  from FastModExp `result`
- `exp_done`  in  1  from FastModExp `done`
- `out_data`  out  32  exponentiation result
- `out_nbytes`  out  2  bytes packed in this block (1..BPB)
- `out_last`  out  1  block was closed by `in_last`
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`

## Operation
- States: COLLECT, START, WAIT, OUTPUT. Reset → COLLECT, byte count 0.
- Key registers reset to 0 → `key_err`=1 after reset. `key_load` honoured only in COLLECT with count 0; ignored otherwise (registers unchanged). `key_err` is combinational on the registered modulus.
- COLLECT: `in_ready = !key_err`. Each accepted byte shifts in big-endian: `acc <= (acc << 8) | in_data`, count+1. Block closes when count reaches BPB or accepted byte has `in_last`=1; latch `last_flag`, `nbytes`; go START. Short blocks are right-aligned, not padded.
- START: `exp_base` = acc zero-extended to 32 bits; `exp_start`=1 this cycle only; go WAIT.
- WAIT: `exp_done` sampled only here; `exp_done`=1 → capture `exp_result` into `out_data`, go OUTPUT. `exp_done` in any other state ignored.
- OUTPUT: `out_valid`=1; `out_data`, `out_nbytes`, `out_last` stable until accept. On `out_valid && out_ready` → COLLECT, count 0, acc 0.
- `exp_base`, `exp_exponent`, `exp_modulo` stable from START through WAIT.
- No new byte accepted outside COLLECT (`in_ready`=0 in START/WAIT/OUTPUT).

## Timing
- Reset values: `in_ready`=0 (key_err), `exp_start`=0, `exp_base`=0, `exp_exponent`=0, `exp_modulo`=0, `out_valid`=0, `out_data`=0, `out_nbytes`=0, `out_last`=0, `key_err`=1.
- Block-closing byte accepted at edge N → `exp_start`=1 during cycle N+1 → WAIT from N+2.
- `exp_done` high at edge M (in WAIT) → `out_valid`=1 from cycle M+1.
- `out_ready` held high: accept in first OUTPUT cycle, `in_ready` high next cycle.
- `rst` mid-operation (any state): all outputs to reset values next cycle, partial block discarded, no further `exp_start`; key registers cleared.
- `key_load` coincident with an accepted byte: byte taken, key load ignored (count no longer 0 at decision — rule: load requires count 0 and no byte accepted that cycle).

## Test plan
- Reset, no key load → `key_err`=1, `in_ready`=0; drive `in_valid` 10 cycles → no byte taken, `exp_start` never pulses.
- Load exp=15432757, mod=16805071; send 0xE6,0x55,0x55 → `exp_base`=0x00E65555, single `exp_start` pulse one cycle after third byte; model done with result 0x00ABCDEF → `out_data`=0x00ABCDEF, `out_nbytes`=3, `out_last`=0.
- Send 0x12, 0x34 with `in_last` on 0x34 → `exp_base`=0x00001234, `out_nbytes`=2, `out_last`=1.
- Load mod=0x00FFFFFF (BPB=3) → `key_err`=1, `in_ready`=0; reload mod=16805071 → `key_err`=0.
- Hold `out_ready`=0 for 20 cycles in OUTPUT → `out_data` stable, `in_ready`=0, spurious `exp_done` pulses ignored; then accept.
- Assert `rst` one cycle during WAIT → all outputs at reset values next cycle; later `exp_done` produces no `out_valid`.

Source files
------------

// File: rtl/crypt_stream_if.sv
// crypt_stream_if
// Bundles every non-clock signal of crypt_stream_ctrl:
//   key load     : key_load, key_exp, key_mod -> key_err
//   byte input   : in_data, in_valid, in_last -> in_ready
//   engine side  : exp_base, exp_exponent, exp_modulo, exp_start <- exp_result, exp_done
//   block output : out_data, out_nbytes, out_last, out_valid <- out_ready
// slave  = the controller, master = whoever drives the stream and models the engine.
interface crypt_stream_if;
   logic        key_load;
   logic [31:0] key_exp;
   logic [31:0] key_mod;
   logic        key_err;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] exp_base;
   logic [31:0] exp_exponent;
   logic [31:0] exp_modulo;
   logic        exp_start;
   logic [31:0] exp_result;
   logic        exp_done;
   logic [31:0] out_data;
   logic [1:0]  out_nbytes;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;

   modport slave (
      input  key_load, key_exp, key_mod, in_data, in_valid, in_last,
             exp_result, exp_done, out_ready,
      output key_err, in_ready, exp_base, exp_exponent, exp_modulo, exp_start,
             out_data, out_nbytes, out_last, out_valid
   );

   modport master (
      output key_load, key_exp, key_mod, in_data, in_valid, in_last,
             exp_result, exp_done, out_ready,
      input  key_err, in_ready, exp_base, exp_exponent, exp_modulo, exp_start,
             out_data, out_nbytes, out_last, out_valid
   );
endinterface

// File: rtl/crypt_stream_ctrl.sv
// crypt_stream_ctrl
// Sequencer in front of a FastModExp engine. Packs BPB input bytes (big-endian,
// short final block right-aligned) into one block, fires one exponentiation per
// block and hands the 32-bit result out on a ready/valid port.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - crypt_stream_if.slave (key load, byte stream, engine, result stream)
module crypt_stream_ctrl #(
   parameter int BPB = 3
) (
   input  logic           clk,
   input  logic           rst,
   crypt_stream_if.slave  bus
);

   localparam int          AW       = 8 * BPB;
   localparam logic [32:0] BLK_MAX  = (33'd1 << AW) - 33'd1;
   localparam logic [1:0]  CNT_LAST = 2'(BPB - 1);

   typedef enum logic [1:0] {COLLECT, START, WAIT, OUTPUT} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] acc;
   logic [1:0]    cnt;
   logic [1:0]    nbytes;
   logic          last_flag;
   logic [31:0]   key_exp_r;
   logic [31:0]   key_mod_r;
   logic [31:0]   out_data_r;

   logic key_err;
   logic in_ready;
   logic exp_start;
   logic out_valid;
   logic byte_take;
   logic blk_close;
   logic key_take;
   logic out_take;

   // A modulus that does not exceed the largest block value cannot hold every
   // block, so the stream is blocked until a usable key is loaded.
   assign key_err   = ({1'b0, key_mod_r} <= BLK_MAX);

   assign byte_take = bus.in_valid && in_ready;
   assign blk_close = byte_take && ((cnt == CNT_LAST) || bus.in_last);
   // Key swap only between blocks, and never in a cycle that consumes a byte.
   assign key_take  = bus.key_load && (state == COLLECT) && (cnt == 2'd0) && !byte_take;
   assign out_take  = out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      exp_start = 1'b0;
      out_valid = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = !key_err;
            if (blk_close) state_nxt = START;
         end
         START: begin
            exp_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.exp_done) state_nxt = OUTPUT;
         end
         OUTPUT: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         cnt        <= 2'd0;
         nbytes     <= 2'd0;
         last_flag  <= 1'b0;
         key_exp_r  <= '0;
         key_mod_r  <= '0;
         out_data_r <= '0;
      end else begin
         if (key_take) begin
            key_exp_r <= bus.key_exp;
            key_mod_r <= bus.key_mod;
         end
         if (byte_take) begin
            acc <= (acc << 8) | AW'(bus.in_data);
            cnt <= cnt + 2'd1;
         end
         if (blk_close) begin
            nbytes    <= cnt + 2'd1;
            last_flag <= bus.in_last;
         end
         // Engine completion is only meaningful while a block is in flight.
         if ((state == WAIT) && bus.exp_done)
            out_data_r <= bus.exp_result;
         if (out_take) begin
            acc <= '0;
            cnt <= 2'd0;
         end
      end
   end

   // acc is untouched from START through WAIT, so the base stays stable there.
   assign bus.exp_base     = {{(32 - AW){1'b0}}, acc};
   assign bus.exp_exponent = key_exp_r;
   assign bus.exp_modulo   = key_mod_r;
   assign bus.exp_start    = exp_start;
   assign bus.key_err      = key_err;
   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid;
   assign bus.out_data     = out_data_r;
   assign bus.out_nbytes   = nbytes;
   assign bus.out_last     = last_flag;

endmodule
